noc_route_alloc: RTL and testbench
==================================

# noc_route_alloc

Parametrised five-port router core: Y-then-X route computation, per-output round-robin switch allocation, credit-based flow control and registered output stage. It sits between the five input FIFOs (N, S, E, W, L) and the five output links of one mesh node. Arbitration, credit tracking and illegal-turn drop accounting are all internal; no external turn tokens are used.

## Interface
Port index in every 5-bit/packed vector: 0=N, 1=S, 2=E, 3=W, 4=L.
- COORD_W, 4, width of one coordinate; flit `DATA_W = 2*COORD_W`, x in `[DATA_W-1:COORD_W]`, y in `[COORD_W-1:0]`
- XCOORD, 0, this node's x coordinate (unsigned, COORD_W bits)
- YCOORD, 0, this node's y coordinate
- CREDITS, 4, downstream buffer depth per output link (≥1)
- DROP_W, 8, width of the drop counter
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  5*DATA_W  head flit of each input FIFO, port i at `[i*DATA_W +: DATA_W]`
- in_valid  in  5  input FIFO non-empty
- in_pop  out  5  combinational; pop head of input i this cycle
- credit_out  out  5  combinational; equal to in_pop, credit returned upstream
- credit_in  in  5  one credit returned by downstream of output j
- out_data  out  5*DATA_W  registered flit per output
- out_valid  out  5  registered; flit on out_data[j] valid for exactly one cycle
- drop_cnt  out  DROP_W  saturating count of dropped flits
- err_credit  out  1  sticky; credit_in received while counter already CREDITS

## Operation
- Route (per input, combinational, unsigned compares): y>YCOORD→S; y<YCOORD→N; else x>XCOORD→E; x<XCOORD→W; else L.
- Legal turns (Y-first, no U-turn): from N: S,E,W,L. From S: N,E,W,L. From E: W,L. From W: E,L. From L: N,S,E,W. Anything else is illegal.
- Illegal flit: dropped in the cycle it is valid regardless of credits; in_pop=1, credit_out=1, no output traffic.
- drop_cnt adds the number of inputs dropping that cycle (0–5) and saturates at all-ones.
- Requests: legal valid input i requests its output j. Output j is eligible only when credit[j] > 0.
- Arbitration per output: round-robin over inputs starting at ptr[j] (ptr, ptr+1, … mod 5). Winner i gets in_pop[i]=1. On grant, ptr[j] becomes (i+1) mod 5; with no grant ptr[j] holds.
- Losing or credit-blocked inputs hold their flit. in_pop=0.
- Each input requests at most one output, so each input gets at most one grant per cycle. Up to 5 grants per cycle on distinct outputs.
- Credit counter per output, range 0..CREDITS: −1 on grant, +1 on credit_in.
  - Both in the same cycle: unchanged.
  - credit_in at CREDITS without a grant: counter holds and err_credit is set.

## Timing
- Reset (async assert, sync release): out_valid=0, out_data=0, drop_cnt=0, err_credit=0, all credit counters=CREDITS, all ptr=0 (N highest priority).
- in_pop/credit_out are valid in the same cycle as in_valid/in_data, with no state dependence beyond counters and pointers.
- Latency: a flit granted in cycle t appears on out_data/out_valid in cycle t+1. Throughput is 1 flit/cycle/output.
- Counter, pointer and drop_cnt updates take effect at the edge ending the grant cycle.
- Credit returned in cycle t is usable for a grant in cycle t+1.
- Reset mid-traffic: registered flits are lost, credits return to CREDITS, err_credit clears.

## Test plan
- XCOORD=1, YCOORD=1. L flit x=1,y=3 with S credits full → in_pop[4]=1 in the same cycle; next cycle out_valid[1]=1, out_data[1]=8'h13.
- N, E and L all target W (x=0,y=1) every cycle with ptr=0 → grants go N, E, L, N… and the W counter decrements 4,3,2,1,0.
- With the W counter at 0 → no grant, every in_pop=0. A credit_in[3] pulse → grant in the next cycle.
- Illegal flits: E with y=2, W with x=0, L with x=1,y=1 presented together → all three pops the same cycle, drop_cnt +3, no out_valid. Drive 300 drops → drop_cnt=8'hFF.
- credit_in[0] with the N counter at CREDITS and no grant → err_credit=1, sticky until rst_n=0. Simultaneous grant and credit_in on S → counter unchanged.
- Assert rst_n low while out_valid is high → out_valid=0 immediately, with no clock edge needed. After release, all counters=CREDITS.

Source files
------------

// File: rtl/noc_route_alloc.sv
// Five-port mesh router core: Y-then-X routing, per-output round-robin switch
// allocation with credit flow control, illegal-turn dropping and registered outputs.
module noc_route_alloc #(
    parameter int                 COORD_W = 4,
    parameter logic [COORD_W-1:0] XCOORD  = '0,
    parameter logic [COORD_W-1:0] YCOORD  = '0,
    parameter int                 CREDITS = 4,
    parameter int                 DROP_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [10*COORD_W-1:0]   in_data,
    input  logic [4:0]              in_valid,
    output logic [4:0]              in_pop,
    output logic [4:0]              credit_out,
    input  logic [4:0]              credit_in,
    output logic [10*COORD_W-1:0]   out_data,
    output logic [4:0]              out_valid,
    output logic [DROP_W-1:0]       drop_cnt,
    output logic                    err_credit
);
    localparam int DATA_W = 2 * COORD_W;
    localparam int CNT_W  = $clog2(CREDITS + 1);
    localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(CREDITS);
    localparam logic [CNT_W-1:0] CRED_ONE = CNT_W'(1);

    // Y-first turn model: once a flit moves in X it may only continue straight or eject.
    function automatic logic turn_ok(input logic [2:0] from, input logic [2:0] to);
        case (from)
            3'd0:    turn_ok = (to != 3'd0);
            3'd1:    turn_ok = (to != 3'd1);
            3'd2:    turn_ok = (to == 3'd3) || (to == 3'd4);
            3'd3:    turn_ok = (to == 3'd2) || (to == 3'd4);
            default: turn_ok = (to != 3'd4);
        endcase
    endfunction

    logic [4:0][2:0] dest;
    logic [4:0]      req;
    logic [4:0]      drop;
    logic [4:0][4:0] gnt;       // gnt[output][input]
    logic [4:0]      err_hit;

    genvar gi;

    for (gi = 0; gi < 5; gi++) begin : g_route
        logic [COORD_W-1:0] flit_x;
        logic [COORD_W-1:0] flit_y;
        logic               legal;

        assign flit_x   = in_data[gi*DATA_W+COORD_W +: COORD_W];
        assign flit_y   = in_data[gi*DATA_W +: COORD_W];
        assign dest[gi] = (flit_y > YCOORD) ? 3'd1 :
                          (flit_y < YCOORD) ? 3'd0 :
                          (flit_x > XCOORD) ? 3'd2 :
                          (flit_x < XCOORD) ? 3'd3 : 3'd4;
        assign legal    = turn_ok(3'(gi), dest[gi]);
        assign req[gi]  = in_valid[gi] & legal;
        assign drop[gi] = in_valid[gi] & ~legal;
    end

    for (gi = 0; gi < 5; gi++) begin : g_out
        logic [CNT_W-1:0]  credit_reg;
        logic [CNT_W-1:0]  credit_next;
        logic [2:0]        ptr_reg;
        logic [2:0]        ptr_next;
        logic              valid_reg;
        logic [DATA_W-1:0] data_reg;
        logic [DATA_W-1:0] win_data;
        logic [4:0]        req_j;
        logic [4:0]        gnt_j;
        logic              granted;

        // Round-robin search starting at ptr; the first requester found wins.
        always_comb begin
            logic       found;
            logic [2:0] idx;
            int         sum;
            req_j    = '0;
            gnt_j    = '0;
            ptr_next = ptr_reg;
            win_data = '0;
            found    = 1'b0;
            idx      = '0;
            sum      = 0;
            for (int i = 0; i < 5; i++) begin
                req_j[i] = req[i] && (dest[i] == 3'(gi));
            end
            if (credit_reg == '0) begin
                req_j = '0;
            end
            for (int k = 0; k < 5; k++) begin
                sum = int'(ptr_reg) + k;
                if (sum >= 5) begin
                    sum = sum - 5;
                end
                idx = 3'(sum);
                if (!found && req_j[idx]) begin
                    found      = 1'b1;
                    gnt_j[idx] = 1'b1;
                    ptr_next   = (idx == 3'd4) ? 3'd0 : idx + 3'd1;
                end
            end
            for (int i = 0; i < 5; i++) begin
                if (gnt_j[i]) begin
                    win_data = in_data[i*DATA_W +: DATA_W];
                end
            end
        end

        assign granted     = |gnt_j;
        assign gnt[gi]     = gnt_j;
        assign err_hit[gi] = credit_in[gi] & ~granted & (credit_reg == CRED_MAX);

        // A grant and a returned credit in the same cycle cancel out.
        always_comb begin
            credit_next = credit_reg;
            if (granted && !credit_in[gi]) begin
                credit_next = credit_reg - CRED_ONE;
            end else if (!granted && credit_in[gi] && (credit_reg != CRED_MAX)) begin
                credit_next = credit_reg + CRED_ONE;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                credit_reg <= CRED_MAX;
                ptr_reg    <= '0;
                valid_reg  <= 1'b0;
                data_reg   <= '0;
            end else begin
                credit_reg <= credit_next;
                ptr_reg    <= ptr_next;
                valid_reg  <= granted;
                if (granted) begin
                    data_reg <= win_data;
                end
            end
        end

        assign out_valid[gi]                   = valid_reg;
        assign out_data[gi*DATA_W +: DATA_W]   = data_reg;
    end

    logic [4:0]        pop_gnt;
    logic [2:0]        drop_num;
    logic [DROP_W:0]   drop_sum;
    logic [DROP_W-1:0] drop_cnt_reg;
    logic              err_credit_reg;

    always_comb begin
        pop_gnt  = '0;
        drop_num = '0;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                pop_gnt[i] = pop_gnt[i] | gnt[j][i];
            end
            drop_num = drop_num + 3'(drop[i]);
        end
    end

    assign drop_sum   = {1'b0, drop_cnt_reg} + (DROP_W+1)'(drop_num);
    assign in_pop     = pop_gnt | drop;
    assign credit_out = in_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_reg   <= '0;
            err_credit_reg <= 1'b0;
        end else begin
            drop_cnt_reg   <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
            err_credit_reg <= err_credit_reg | (|err_hit);
        end
    end

    assign drop_cnt   = drop_cnt_reg;
    assign err_credit = err_credit_reg;

endmodule

// File: tb/tb_noc_route_alloc.sv
// Scoreboard bench for noc_route_alloc at node (1,1): directed vectors push expected
// output flits; a negedge monitor matches them against out_valid/out_data.
module tb_noc_route_alloc;
    localparam int COORD_W = 4;
    localparam int DATA_W  = 8;
    localparam int CREDITS = 4;
    localparam int DROP_W  = 8;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [5*DATA_W-1:0]   in_data = '0;
    logic [4:0]            in_valid = '0;
    logic [4:0]            in_pop;
    logic [4:0]            credit_out;
    logic [4:0]            credit_in = '0;
    logic [5*DATA_W-1:0]   out_data;
    logic [4:0]            out_valid;
    logic [DROP_W-1:0]     drop_cnt;
    logic                  err_credit;

    typedef struct {
        int         port;
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    noc_route_alloc #(
        .COORD_W (COORD_W),
        .XCOORD  (4'd1),
        .YCOORD  (4'd1),
        .CREDITS (CREDITS),
        .DROP_W  (DROP_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_pop     (in_pop),
        .credit_out (credit_out),
        .credit_in  (credit_in),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .drop_cnt   (drop_cnt),
        .err_credit (err_credit)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: 0x%0h (cycle %0d)", name, act, cyc);
        end
    endtask

    task automatic expect_out(input int p, input logic [7:0] d);
        exp_t e;
        e.port = p;
        e.data = d;
        e.due  = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic set_flit(input int p, input logic [3:0] x, input logic [3:0] y);
        in_data[p*DATA_W +: DATA_W] = {x, y};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tick();
        in_valid  = '0;
        credit_in = '0;
    endtask

    task automatic apply(input logic [4:0] v, input logic [4:0] cin,
                         input logic [4:0] exp_pop, input string name);
        in_valid  = v;
        credit_in = cin;
        #1;
        chk({name, " in_pop"}, 32'(in_pop), 32'(exp_pop));
        chk({name, " credit_out"}, 32'(credit_out), 32'(exp_pop));
    endtask

    // Monitor: every flit seen must match an expectation due this cycle; overdue ones are missing.
    always @(negedge clk) begin
        int hit;
        for (int j = 0; j < 5; j++) begin
            if (out_valid[j] === 1'b1) begin
                hit = -1;
                for (int k = 0; k < sb.size(); k++) begin
                    if (hit < 0 && sb[k].port == j && sb[k].due == cyc) hit = k;
                end
                n_vec++;
                if (hit < 0) begin
                    n_err++;
                    $display("FAIL out%0d flit: got 0x%0h, required no flit (cycle %0d)",
                             j, out_data[j*DATA_W +: DATA_W], cyc);
                end else begin
                    if (out_data[j*DATA_W +: DATA_W] !== sb[hit].data) begin
                        n_err++;
                        $display("FAIL out%0d flit: got 0x%0h, required 0x%0h (cycle %0d)",
                                 j, out_data[j*DATA_W +: DATA_W], sb[hit].data, cyc);
                    end else begin
                        $display("ok   out%0d flit: 0x%0h (cycle %0d)", j, sb[hit].data, cyc);
                    end
                    sb.delete(hit);
                end
            end
        end
        for (int k = sb.size() - 1; k >= 0; k--) begin
            if (sb[k].due <= cyc) begin
                n_vec++;
                n_err++;
                $display("FAIL out%0d flit: got none, required 0x%0h (cycle %0d)",
                         sb[k].port, sb[k].data, cyc);
                sb.delete(k);
            end
        end
    end

    initial begin
        // reset state
        #12;
        chk("reset out_valid", 32'(out_valid), 32'h0);
        chk("reset drop_cnt", 32'(drop_cnt), 32'h0);
        chk("reset err_credit", 32'(err_credit), 32'h0);
        chk("reset in_pop", 32'(in_pop), 32'h0);
        #10 rst_n = 1'b1;

        // L flit to (1,3) routes south
        tick();
        set_flit(4, 4'd1, 4'd3);
        apply(5'b10000, 5'b00000, 5'b10000, "L->S");
        expect_out(1, 8'h13);
        idle();
        apply(5'b00000, 5'b00010, 5'b00000, "S credit return");

        // N, E, L contend for W
        idle();
        set_flit(0, 4'd0, 4'd1);
        set_flit(2, 4'd0, 4'd1);
        set_flit(4, 4'd0, 4'd1);
        apply(5'b10101, 5'b00000, 5'b00001, "W rr N");
        expect_out(3, 8'h01);
        tick();
        apply(5'b10101, 5'b00000, 5'b00100, "W rr E");
        expect_out(3, 8'h01);
        tick();
        apply(5'b10101, 5'b00000, 5'b10000, "W rr L");
        expect_out(3, 8'h01);
        tick();
        apply(5'b10101, 5'b00000, 5'b00001, "W rr N again");
        expect_out(3, 8'h01);
        tick();
        apply(5'b10101, 5'b00000, 5'b00000, "W no credit");
        tick();
        apply(5'b10101, 5'b01000, 5'b00000, "W credit arrives");
        tick();
        apply(5'b10101, 5'b00000, 5'b00100, "W regrant E");
        expect_out(3, 8'h01);
        tick();
        apply(5'b10101, 5'b00000, 5'b00000, "W empty again");
        for (int n = 0; n < 4; n++) begin
            tick();
            apply(5'b00000, 5'b01000, 5'b00000, "W credit refill");
        end
        idle();
        chk("err_credit after W refill", 32'(err_credit), 32'h0);

        // grant and credit on S in the same cycle leaves the counter at 4
        set_flit(0, 4'd1, 4'd3);
        apply(5'b00001, 5'b00010, 5'b00001, "S grant+credit");
        expect_out(1, 8'h13);
        for (int n = 0; n < 4; n++) begin
            tick();
            apply(5'b00001, 5'b00000, 5'b00001, "S drain");
            expect_out(1, 8'h13);
        end
        tick();
        apply(5'b00001, 5'b00000, 5'b00000, "S exhausted");
        for (int n = 0; n < 4; n++) begin
            tick();
            apply(5'b00000, 5'b00010, 5'b00000, "S credit refill");
        end
        idle();
        chk("err_credit after S refill", 32'(err_credit), 32'h0);

        // spurious credit on a full N counter
        apply(5'b00000, 5'b00001, 5'b00000, "N spurious credit");
        idle();
        chk("err_credit set", 32'(err_credit), 32'h1);
        idle();
        idle();
        chk("err_credit sticky", 32'(err_credit), 32'h1);

        // three illegal turns at once, then saturation
        set_flit(2, 4'd1, 4'd2);
        set_flit(3, 4'd0, 4'd1);
        set_flit(4, 4'd1, 4'd1);
        for (int n = 1; n <= 100; n++) begin
            tick();
            if (n == 2)  chk("drop_cnt after 1 cycle", 32'(drop_cnt), 32'd3);
            if (n == 51) chk("drop_cnt after 50 cycles", 32'(drop_cnt), 32'd150);
            if (n == 85) chk("drop_cnt after 84 cycles", 32'(drop_cnt), 32'd252);
            apply(5'b11100, 5'b00000, 5'b11100, "drop E/W/L");
        end
        idle();
        chk("drop_cnt saturated", 32'(drop_cnt), 32'hFF);

        // asynchronous reset while a flit is on the output
        set_flit(4, 4'd1, 4'd3);
        apply(5'b10000, 5'b00000, 5'b10000, "pre-reset L->S");
        idle();
        chk("pre-reset out_valid", 32'(out_valid), 32'h02);
        chk("pre-reset out_data S", 32'(out_data[15:8]), 32'h13);
        #1 rst_n = 1'b0;
        #1;
        chk("async reset out_valid", 32'(out_valid), 32'h0);
        chk("async reset out_data S", 32'(out_data[15:8]), 32'h0);
        chk("async reset err_credit", 32'(err_credit), 32'h0);
        chk("async reset drop_cnt", 32'(drop_cnt), 32'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            tick();
            apply(5'b10000, 5'b00000, 5'b10000, "post-reset S credit");
            expect_out(1, 8'h13);
        end
        tick();
        apply(5'b10000, 5'b00000, 5'b00000, "post-reset S exhausted");
        idle();
        chk("post-reset err_credit", 32'(err_credit), 32'h0);
        chk("post-reset drop_cnt", 32'(drop_cnt), 32'h0);
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
